// File: rtl/imem_loader.sv
// Framed byte-stream loader that fills instruction memory and gates the CPU until a valid image is present.
// Latency: each payload byte is written to memory 1 cycle after it is accepted. Backpressure: none, in_ready is always 1.
// Optional checksum trailer byte and CHECK state are enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int          MEM_SIZE  = 1024,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_wEn,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] bytes_written
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR_LO,
        ADDR_HI,
        LEN_LO,
        LEN_HI,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] MEM_SIZE_W = 32'(MEM_SIZE);

    state_t      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [15:0] len_q, len_d;
    logic [15:0] bytes_written_q, bytes_written_d;
    logic        mem_wen_q, mem_wen_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        load_done_q, load_done_d;
    logic        load_err_q, load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic [15:0] len_full;
    logic [16:0] end_sum;
    logic        range_bad;
    logic [15:0] bw_inc;

    // Range check uses the length being completed by the current LEN_HI byte.
    assign len_full  = {in_data, len_q[7:0]};
    assign end_sum   = {1'b0, base_q} + {1'b0, len_full};
    assign range_bad = {15'd0, end_sum} > MEM_SIZE_W;
    assign bw_inc    = bytes_written_q + 16'd1;

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        len_d           = len_q;
        bytes_written_d = bytes_written_q;
        mem_wen_d       = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        cpu_hold_d      = cpu_hold_q;
        load_done_d     = load_done_q;
        load_err_d      = load_err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d          = csum_q;
`endif
        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    if (in_data == SYNC_BYTE) state_d = ADDR_LO;
                end
                ADDR_LO: begin
                    base_d[7:0] = in_data;
                    state_d     = ADDR_HI;
                end
                ADDR_HI: begin
                    base_d[15:8] = in_data;
                    state_d      = LEN_LO;
                end
                LEN_LO: begin
                    len_d[7:0] = in_data;
                    state_d    = LEN_HI;
                end
                LEN_HI: begin
                    len_d[15:8]     = in_data;
                    bytes_written_d = 16'd0;
                    load_done_d     = 1'b0;
                    load_err_d      = 1'b0;
                    cpu_hold_d      = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d          = 8'd0;
`endif
                    if (range_bad) begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                    end else if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d     = CHECK;
`else
                        state_d     = DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
`endif
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    mem_wen_d       = 1'b1;
                    mem_addr_d      = 64'(base_q) + 64'(bytes_written_q);
                    mem_wdata_d     = in_data;
                    bytes_written_d = bw_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d          = csum_q + in_data;
                    if (bw_inc == len_q) state_d = CHECK;
`else
                    if (bw_inc == len_q) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (in_data == csum_q) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                        cpu_hold_d = 1'b1;
                    end
                end
`endif
                // The image stays live (hold low) until a new frame commits at LEN_HI.
                DONE, ERR: begin
                    if (in_data == SYNC_BYTE) state_d = ADDR_LO;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            base_q          <= 16'd0;
            len_q           <= 16'd0;
            bytes_written_q <= 16'd0;
            mem_wen_q       <= 1'b0;
            mem_addr_q      <= 64'd0;
            mem_wdata_q     <= 8'd0;
            cpu_hold_q      <= 1'b1;
            load_done_q     <= 1'b0;
            load_err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q          <= 8'd0;
`endif
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            len_q           <= len_d;
            bytes_written_q <= bytes_written_d;
            mem_wen_q       <= mem_wen_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            cpu_hold_q      <= cpu_hold_d;
            load_done_q     <= load_done_d;
            load_err_q      <= load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q          <= csum_d;
`endif
        end
    end

    assign in_ready      = 1'b1;
    assign mem_wEn       = mem_wen_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign load_done     = load_done_q;
    assign load_err      = load_err_q;
    assign bytes_written = bytes_written_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; frame endings adapt to IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_wEn;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] bytes_written;

    int checks = 0;
    int errors = 0;
    int wen_cnt = 0;

    imem_loader #(.MEM_SIZE(1024), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_wEn(mem_wEn), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_err(load_err), .bytes_written(bytes_written)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_wEn === 1'b1) wen_cnt++;

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle(3);
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_hold got %b want 1", cpu_hold); end
        checks++; if (load_done !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL reset_flags got done=%b err=%b want 0/0", load_done, load_err); end
        checks++; if (mem_wEn !== 1'b0 || mem_addr !== 64'd0 || mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_mem got wEn=%b addr=%h data=%h want 0", mem_wEn, mem_addr, mem_wdata); end
        checks++; if (in_ready !== 1'b1 || bytes_written !== 16'd0) begin errors++; $display("FAIL reset_ready_bw got rdy=%b bw=%0d want 1/0", in_ready, bytes_written); end
        @(negedge clk); rst = 1'b1;
        send(8'h00); send(8'hFF); idle(1);
        checks++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || mem_wEn !== 1'b0) begin errors++; $display("FAIL idle_noise got hold=%b done=%b wEn=%b want 1/0/0", cpu_hold, load_done, mem_wEn); end
    endtask

    task automatic test_good_frame;
        logic [7:0] d [3] = '{8'h30, 8'hF2, 8'h0A};
        send(8'hA5); send(8'h10); send(8'h00); send(8'h03); send(8'h00);
        checks++; if (cpu_hold !== 1'b1 || bytes_written !== 16'd0) begin errors++; $display("FAIL good_hdr got hold=%b bw=%0d want 1/0", cpu_hold, bytes_written); end
        for (int i = 0; i < 3; i++) begin
            send(d[i]);
            checks++; if (mem_wEn !== 1'b1 || mem_addr !== 64'h10 + 64'(i) || mem_wdata !== d[i]) begin errors++; $display("FAIL good_write%0d got wEn=%b addr=%h data=%h want 1/%h/%h", i, mem_wEn, mem_addr, mem_wdata, 64'h10 + 64'(i), d[i]); end
        end
        checks++; if (bytes_written !== 16'd3) begin errors++; $display("FAIL good_bw got %0d want 3", bytes_written); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL good_predone got %b want 0", load_done); end
`endif
        send(8'h2C);
        checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0 || load_err !== 1'b0 || mem_wEn !== 1'b0) begin errors++; $display("FAIL good_done got done=%b hold=%b err=%b wEn=%b want 1/0/0/0", load_done, cpu_hold, load_err, mem_wEn); end
    endtask

    task automatic test_bad_checksum;
        int c0;
        c0 = wen_cnt;
        send(8'hA5); send(8'h10); send(8'h00); send(8'h03); send(8'h00);
        send(8'h30); send(8'hF2); send(8'h0A); send(8'h2D);
        idle(2);
        checks++; if (wen_cnt - c0 !== 3) begin errors++; $display("FAIL bad_writes got %0d want 3", wen_cnt - c0); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        checks++; if (load_err !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL bad_csum got err=%b hold=%b done=%b want 1/1/0", load_err, cpu_hold, load_done); end
`else
        checks++; if (load_err !== 1'b0 || cpu_hold !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL bad_trailer got err=%b hold=%b done=%b want 0/0/1", load_err, cpu_hold, load_done); end
`endif
    endtask

    task automatic test_range;
        int c0;
        c0 = wen_cnt;
        send(8'hA5); send(8'hFE); send(8'h03); send(8'h04); send(8'h00);
        checks++; if (load_err !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL range_rej got err=%b hold=%b done=%b want 1/1/0", load_err, cpu_hold, load_done); end
        idle(2);
        checks++; if (wen_cnt !== c0) begin errors++; $display("FAIL range_nowrite got %0d want 0", wen_cnt - c0); end
        send(8'hA5); send(8'hFC); send(8'h03); send(8'h04); send(8'h00);
        checks++; if (load_err !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL range_edge_hdr got err=%b hold=%b want 0/1", load_err, cpu_hold); end
        for (int i = 0; i < 4; i++) begin
            send(8'(i + 1));
            checks++; if (mem_wEn !== 1'b1 || mem_addr !== 64'h3FC + 64'(i)) begin errors++; $display("FAIL range_edge_write%0d got wEn=%b addr=%h want 1/%h", i, mem_wEn, mem_addr, 64'h3FC + 64'(i)); end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h0A);
`endif
        checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL range_edge_done got done=%b hold=%b want 1/0", load_done, cpu_hold); end
    endtask

    task automatic test_noise_stalls;
        logic [7:0] d [3] = '{8'h11, 8'h22, 8'h33};
        int c0;
        send(8'h00); send(8'hFF);
        checks++; if (load_done !== 1'b1 || mem_wEn !== 1'b0) begin errors++; $display("FAIL noise_done got done=%b wEn=%b want 1/0", load_done, mem_wEn); end
        send(8'hA5); send(8'h40); send(8'h00); send(8'h03); send(8'h00);
        c0 = wen_cnt;
        for (int i = 0; i < 3; i++) begin
            send(d[i]);
            checks++; if (mem_wEn !== 1'b1 || mem_addr !== 64'h40 + 64'(i) || mem_wdata !== d[i]) begin errors++; $display("FAIL stall_write%0d got wEn=%b addr=%h data=%h want 1/%h/%h", i, mem_wEn, mem_addr, mem_wdata, 64'h40 + 64'(i), d[i]); end
            for (int g = 0; g < 3; g++) begin
                idle(1);
                checks++; if (mem_wEn !== 1'b0) begin errors++; $display("FAIL stall_gap%0d_%0d got wEn=%b want 0", i, g, mem_wEn); end
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h66);
`endif
        idle(2);
        checks++; if (wen_cnt - c0 !== 3 || load_done !== 1'b1) begin errors++; $display("FAIL stall_total got writes=%0d done=%b want 3/1", wen_cnt - c0, load_done); end
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        checks++; if (load_done !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL zero_pre got done=%b hold=%b want 0/1", load_done, cpu_hold); end
`endif
        send(8'h00);
        checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0 || load_err !== 1'b0 || bytes_written !== 16'd0) begin errors++; $display("FAIL zero_len got done=%b hold=%b err=%b bw=%0d want 1/0/0/0", load_done, cpu_hold, load_err, bytes_written); end
    endtask

    task automatic test_reload;
        send(8'hA5); send(8'h20); send(8'h00); send(8'h01);
        checks++; if (cpu_hold !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL reload_prelen got hold=%b done=%b want 0/1", cpu_hold, load_done); end
        send(8'h00);
        checks++; if (cpu_hold !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL reload_lenhi got hold=%b done=%b want 1/0", cpu_hold, load_done); end
        send(8'h90);
        checks++; if (mem_wEn !== 1'b1 || mem_addr !== 64'h20 || mem_wdata !== 8'h90) begin errors++; $display("FAIL reload_write got wEn=%b addr=%h data=%h want 1/20/90", mem_wEn, mem_addr, mem_wdata); end
        send(8'h90);
        checks++; if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL reload_done got done=%b hold=%b want 1/0", load_done, cpu_hold); end
    endtask

    task automatic test_reset_abort;
        int c0;
        send(8'hA5); send(8'h00); send(8'h01); send(8'h04); send(8'h00);
        send(8'h01); send(8'h02);
        checks++; if (mem_wEn !== 1'b1 || mem_addr !== 64'h101) begin errors++; $display("FAIL abort_pre got wEn=%b addr=%h want 1/101", mem_wEn, mem_addr); end
        #2; rst = 1'b0; #1;
        checks++; if (mem_wEn !== 1'b0 || mem_addr !== 64'd0 || mem_wdata !== 8'd0) begin errors++; $display("FAIL abort_mem got wEn=%b addr=%h data=%h want 0", mem_wEn, mem_addr, mem_wdata); end
        checks++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 || bytes_written !== 16'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_ctl got hold=%b done=%b err=%b bw=%0d rdy=%b want 1/0/0/0/1", cpu_hold, load_done, load_err, bytes_written, in_ready); end
        @(negedge clk); rst = 1'b1;
        c0 = wen_cnt;
        send(8'h03); idle(2);
        checks++; if (wen_cnt !== c0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL abort_idle got writes=%0d hold=%b want 0/1", wen_cnt - c0, cpu_hold); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bad_checksum;
        test_range;
        test_noise_stalls;
        test_good_frame;
        test_reload;
        test_reset_abort;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
